// File: rtl/ysyx_22040931_id_pipe_if.sv
// IF/ID-to-EX handshake bundle for the pipelined decode stage, including the forwarding taps.
// The slave modport is the decode stage; the master side drives instructions, producers and EX ready.
interface ysyx_22040931_id_pipe_if #(
   parameter int XLEN  = 64,
   parameter int CTRLW = 16,
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic             id_ready;
   logic [XLEN-1:0]  pc_i;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic             rs1_used;
   logic             rs2_used;
   logic [4:0]       rd_addr;
   logic             rd_wen;
   logic             is_load;
   logic [1:0]       br_type;
   logic [2:0]       br_cond;
   logic [XLEN-1:0]  imm;
   logic             use_imm;
   logic [CTRLW-1:0] ctrl_i;
   logic [XLEN-1:0]  rf_data1;
   logic [XLEN-1:0]  rf_data2;
   logic             ex_fwd_wen;
   logic [4:0]       ex_fwd_rd;
   logic [XLEN-1:0]  ex_fwd_data;
   logic             ex_fwd_load;
   logic             mem_fwd_wen;
   logic [4:0]       mem_fwd_rd;
   logic [XLEN-1:0]  mem_fwd_data;
   logic             wb_fwd_wen;
   logic [4:0]       wb_fwd_rd;
   logic [XLEN-1:0]  wb_fwd_data;
   logic             flush;
   logic             ex_ready;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_data1;
   logic [XLEN-1:0]  ex_data2;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rd;
   logic             ex_rd_wen;
   logic             ex_is_load;
   logic [CTRLW-1:0] ex_ctrl;
   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  id_valid, pc_i, rs1_addr, rs2_addr, rs1_used, rs2_used, rd_addr, rd_wen,
             is_load, br_type, br_cond, imm, use_imm, ctrl_i, rf_data1, rf_data2,
             ex_fwd_wen, ex_fwd_rd, ex_fwd_data, ex_fwd_load,
             mem_fwd_wen, mem_fwd_rd, mem_fwd_data,
             wb_fwd_wen, wb_fwd_rd, wb_fwd_data, flush, ex_ready,
      output id_ready, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_rd_wen,
             ex_is_load, ex_ctrl, redirect, redirect_pc, stall_cnt
   );

   modport master (
      output id_valid, pc_i, rs1_addr, rs2_addr, rs1_used, rs2_used, rd_addr, rd_wen,
             is_load, br_type, br_cond, imm, use_imm, ctrl_i, rf_data1, rf_data2,
             ex_fwd_wen, ex_fwd_rd, ex_fwd_data, ex_fwd_load,
             mem_fwd_wen, mem_fwd_rd, mem_fwd_data,
             wb_fwd_wen, wb_fwd_rd, wb_fwd_data, flush, ex_ready,
      input  id_ready, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_rd_wen,
             ex_is_load, ex_ctrl, redirect, redirect_pc, stall_cnt
   );
endinterface

// File: rtl/ysyx_22040931_id_pipe.sv
// Pipelined ID stage: operand forwarding/interlock, branch resolution, registered ID/EX payload (1 cycle).
// Back-pressure: id_ready drops on a hazard or when EX holds valid data; the payload is held, never bubbled.
module ysyx_22040931_id_pipe #(
   parameter int XLEN   = 64,
   parameter int CTRLW  = 16,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic clock,
   input  logic reset,
   ysyx_22040931_id_pipe_if.slave bus
);
   localparam logic [1:0] BR_JALR = 2'd1;
   localparam logic [1:0] BR_COND = 2'd2;
   localparam logic [1:0] BR_JAL  = 2'd3;

   logic             r_ex_valid;
   logic [XLEN-1:0]  r_ex_pc;
   logic [XLEN-1:0]  r_ex_data1;
   logic [XLEN-1:0]  r_ex_data2;
   logic [XLEN-1:0]  r_ex_imm;
   logic [4:0]       r_ex_rd;
   logic             r_ex_rd_wen;
   logic             r_ex_is_load;
   logic [CTRLW-1:0] r_ex_ctrl;
   logic [CNT_W-1:0] r_stall_cnt;

   logic            w_ex_m1, w_mem_m1, w_wb_m1;
   logic            w_ex_m2, w_mem_m2, w_wb_m2;
   logic [XLEN-1:0] w_op1, w_op2;
   logic            w_haz1, w_haz2, w_hazard;
   logic            w_cond, w_jump, w_taken;
   logic [XLEN-1:0] w_jalr_sum, w_tgt;
   logic [XLEN-1:0] w_d1, w_d2;
   logic            w_id_ready, w_fire, w_redirect;

   assign w_ex_m1  = bus.ex_fwd_wen  && (bus.ex_fwd_rd  == bus.rs1_addr);
   assign w_mem_m1 = bus.mem_fwd_wen && (bus.mem_fwd_rd == bus.rs1_addr);
   assign w_wb_m1  = bus.wb_fwd_wen  && (bus.wb_fwd_rd  == bus.rs1_addr);
   assign w_ex_m2  = bus.ex_fwd_wen  && (bus.ex_fwd_rd  == bus.rs2_addr);
   assign w_mem_m2 = bus.mem_fwd_wen && (bus.mem_fwd_rd == bus.rs2_addr);
   assign w_wb_m2  = bus.wb_fwd_wen  && (bus.wb_fwd_rd  == bus.rs2_addr);

   // Youngest producer wins; x0 is hard-wired to zero regardless of any producer.
   always_comb begin
      w_op1 = '0;
      if (bus.rs1_addr != 5'd0) begin
         if (w_ex_m1)       w_op1 = bus.ex_fwd_data;
         else if (w_mem_m1) w_op1 = bus.mem_fwd_data;
         else if (w_wb_m1)  w_op1 = bus.wb_fwd_data;
         else               w_op1 = bus.rf_data1;
      end
   end

   always_comb begin
      w_op2 = '0;
      if (bus.rs2_addr != 5'd0) begin
         if (w_ex_m2)       w_op2 = bus.ex_fwd_data;
         else if (w_mem_m2) w_op2 = bus.mem_fwd_data;
         else if (w_wb_m2)  w_op2 = bus.wb_fwd_data;
         else               w_op2 = bus.rf_data2;
      end
   end

   always_comb begin
      w_haz1 = 1'b0;
      w_haz2 = 1'b0;
      if (bus.rs1_used && (bus.rs1_addr != 5'd0)) begin
         if (FWD_EN != 0) w_haz1 = w_ex_m1 && bus.ex_fwd_load;
         else             w_haz1 = w_ex_m1 || w_mem_m1 || w_wb_m1;
      end
      if (bus.rs2_used && (bus.rs2_addr != 5'd0)) begin
         if (FWD_EN != 0) w_haz2 = w_ex_m2 && bus.ex_fwd_load;
         else             w_haz2 = w_ex_m2 || w_mem_m2 || w_wb_m2;
      end
   end

   assign w_hazard = w_haz1 || w_haz2;

   // funct3 010/011 are not branch encodings and are treated as never taken.
   always_comb begin
      w_cond = 1'b0;
      case (bus.br_cond)
         3'b000:  w_cond = (w_op1 == w_op2);
         3'b001:  w_cond = (w_op1 != w_op2);
         3'b100:  w_cond = ($signed(w_op1) <  $signed(w_op2));
         3'b101:  w_cond = ($signed(w_op1) >= $signed(w_op2));
         3'b110:  w_cond = (w_op1 <  w_op2);
         3'b111:  w_cond = (w_op1 >= w_op2);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_jump     = (bus.br_type == BR_JAL) || (bus.br_type == BR_JALR);
   assign w_taken    = w_jump || ((bus.br_type == BR_COND) && w_cond);
   assign w_jalr_sum = w_op1 + bus.imm;
   assign w_tgt      = (bus.br_type == BR_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                                : (bus.pc_i + bus.imm);

   // Link value is computed in EX as pc + 4.
   assign w_d1 = w_jump ? bus.pc_i : w_op1;
   assign w_d2 = w_jump ? XLEN'(4) : (bus.use_imm ? bus.imm : w_op2);

   assign w_id_ready = !w_hazard && (!r_ex_valid || bus.ex_ready);
   assign w_fire     = bus.id_valid && w_id_ready;
   assign w_redirect = w_fire && w_taken && !bus.flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ex_valid   <= 1'b0;
         r_ex_pc      <= '0;
         r_ex_data1   <= '0;
         r_ex_data2   <= '0;
         r_ex_imm     <= '0;
         r_ex_rd      <= '0;
         r_ex_rd_wen  <= 1'b0;
         r_ex_is_load <= 1'b0;
         r_ex_ctrl    <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (bus.flush) begin
            r_ex_valid <= 1'b0;
         end else if (w_fire) begin
            r_ex_valid   <= 1'b1;
            r_ex_pc      <= bus.pc_i;
            r_ex_data1   <= w_d1;
            r_ex_data2   <= w_d2;
            r_ex_imm     <= bus.imm;
            r_ex_rd      <= bus.rd_addr;
            r_ex_rd_wen  <= bus.rd_wen;
            r_ex_is_load <= bus.is_load;
            r_ex_ctrl    <= bus.ctrl_i;
         end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
         end
         if (bus.id_valid && w_hazard && !bus.flush && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.id_ready    = w_id_ready;
   assign bus.ex_valid    = r_ex_valid;
   assign bus.ex_pc       = r_ex_pc;
   assign bus.ex_data1    = r_ex_data1;
   assign bus.ex_data2    = r_ex_data2;
   assign bus.ex_imm      = r_ex_imm;
   assign bus.ex_rd       = r_ex_rd;
   assign bus.ex_rd_wen   = r_ex_rd_wen;
   assign bus.ex_is_load  = r_ex_is_load;
   assign bus.ex_ctrl     = r_ex_ctrl;
   assign bus.redirect    = w_redirect;
   assign bus.redirect_pc = w_redirect ? w_tgt : '0;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_ysyx_22040931_id_pipe.sv
// Directed bench: FWD_EN=1 instance checked through a payload scoreboard, FWD_EN=0 instance for interlock.
module tb_ysyx_22040931_id_pipe;
   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic        wen;
      logic        ld;
      logic [15:0] ctrl;
   } exp_t;

   logic clock;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t drop;

   ysyx_22040931_id_pipe_if a_if ();
   ysyx_22040931_id_pipe_if b_if ();

   ysyx_22040931_id_pipe #(.XLEN(64), .CTRLW(16), .FWD_EN(1), .CNT_W(32)) u_dut_fwd (
      .clock (clock),
      .reset (reset),
      .bus   (a_if)
   );

   ysyx_22040931_id_pipe #(.XLEN(64), .CTRLW(16), .FWD_EN(0), .CNT_W(32)) u_dut_stall (
      .clock (clock),
      .reset (reset),
      .bus   (b_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_a();
      a_if.id_valid = 0; a_if.pc_i = 0; a_if.rs1_addr = 0; a_if.rs2_addr = 0;
      a_if.rs1_used = 0; a_if.rs2_used = 0; a_if.rd_addr = 0; a_if.rd_wen = 0;
      a_if.is_load = 0; a_if.br_type = 0; a_if.br_cond = 0; a_if.imm = 0;
      a_if.use_imm = 0; a_if.ctrl_i = 0; a_if.rf_data1 = 0; a_if.rf_data2 = 0;
      a_if.ex_fwd_wen = 0; a_if.ex_fwd_rd = 0; a_if.ex_fwd_data = 0; a_if.ex_fwd_load = 0;
      a_if.mem_fwd_wen = 0; a_if.mem_fwd_rd = 0; a_if.mem_fwd_data = 0;
      a_if.wb_fwd_wen = 0; a_if.wb_fwd_rd = 0; a_if.wb_fwd_data = 0;
      a_if.flush = 0; a_if.ex_ready = 1;
   endtask

   task automatic clr_b();
      b_if.id_valid = 0; b_if.pc_i = 0; b_if.rs1_addr = 0; b_if.rs2_addr = 0;
      b_if.rs1_used = 0; b_if.rs2_used = 0; b_if.rd_addr = 0; b_if.rd_wen = 0;
      b_if.is_load = 0; b_if.br_type = 0; b_if.br_cond = 0; b_if.imm = 0;
      b_if.use_imm = 0; b_if.ctrl_i = 0; b_if.rf_data1 = 0; b_if.rf_data2 = 0;
      b_if.ex_fwd_wen = 0; b_if.ex_fwd_rd = 0; b_if.ex_fwd_data = 0; b_if.ex_fwd_load = 0;
      b_if.mem_fwd_wen = 0; b_if.mem_fwd_rd = 0; b_if.mem_fwd_data = 0;
      b_if.wb_fwd_wen = 0; b_if.wb_fwd_rd = 0; b_if.wb_fwd_data = 0;
      b_if.flush = 0; b_if.ex_ready = 1;
   endtask

   task automatic instr(input logic [63:0] pc, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic [1:0] br,
                        input logic [2:0] cond, input logic [63:0] imm, input logic ui,
                        input logic [15:0] ctrl);
      a_if.id_valid = 1; a_if.pc_i = pc; a_if.rs1_addr = r1; a_if.rs1_used = u1;
      a_if.rs2_addr = r2; a_if.rs2_used = u2; a_if.rd_addr = rd; a_if.rd_wen = wen;
      a_if.is_load = ld; a_if.br_type = br; a_if.br_cond = cond; a_if.imm = imm;
      a_if.use_imm = ui; a_if.ctrl_i = ctrl;
   endtask

   // EX consumes the payload at the next rising edge whenever valid and ready are both high.
   always @(negedge clock) begin
      if (!reset && a_if.ex_valid && a_if.ex_ready && !a_if.flush) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ex_pc", a_if.ex_pc, e.pc);
            chk("ex_data1", a_if.ex_data1, e.d1);
            chk("ex_data2", a_if.ex_data2, e.d2);
            chk("ex_imm", a_if.ex_imm, e.imm);
            chk("ex_rd", {59'd0, a_if.ex_rd}, {59'd0, e.rd});
            chk("ex_rd_wen", {63'd0, a_if.ex_rd_wen}, {63'd0, e.wen});
            chk("ex_is_load", {63'd0, a_if.ex_is_load}, {63'd0, e.ld});
            chk("ex_ctrl", {48'd0, a_if.ex_ctrl}, {48'd0, e.ctrl});
         end
      end
   end

   logic [2:0]  br_cond_tab [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000, 3'b010};
   logic        br_take_tab [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      reset = 1'b1;
      clr_a();
      clr_b();
      #2;
      chk("rst_ex_valid", {63'd0, a_if.ex_valid}, 64'd0);
      chk("rst_ex_pc", a_if.ex_pc, 64'd0);
      chk("rst_ex_data1", a_if.ex_data1, 64'd0);
      chk("rst_redirect", {63'd0, a_if.redirect}, 64'd0);
      chk("rst_stall_cnt", {32'd0, a_if.stall_cnt}, 64'd0);
      chk("rst_id_ready", {63'd0, a_if.id_ready}, 64'd1);
      tick();
      reset = 1'b0;
      tick();

      // ADDI x1, x0, 5
      clr_a();
      instr(64'h100, 5'd0, 1, 5'd0, 0, 5'd1, 1, 0, 2'd0, 3'd0, 64'd5, 1, 16'h0011);
      #1;
      chk("addi_id_ready", {63'd0, a_if.id_ready}, 64'd1);
      chk("addi_redirect", {63'd0, a_if.redirect}, 64'd0);
      sb.push_back('{64'h100, 64'd0, 64'd5, 64'd5, 5'd1, 1'b1, 1'b0, 16'h0011});
      tick();

      // ADD x2, x1, x1 with EX and an older MEM producer both writing x1
      clr_a();
      instr(64'h104, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 2'd0, 3'd0, 64'd0, 0, 16'h0022);
      a_if.ex_fwd_wen = 1; a_if.ex_fwd_rd = 5'd1; a_if.ex_fwd_data = 64'd5;
      a_if.mem_fwd_wen = 1; a_if.mem_fwd_rd = 5'd1; a_if.mem_fwd_data = 64'h77;
      a_if.rf_data1 = 64'hDEAD; a_if.rf_data2 = 64'hDEAD;
      #1;
      chk("add_id_ready", {63'd0, a_if.id_ready}, 64'd1);
      sb.push_back('{64'h104, 64'd5, 64'd5, 64'd0, 5'd2, 1'b1, 1'b0, 16'h0022});
      tick();
      chk("add_stall_cnt", {32'd0, a_if.stall_cnt}, 64'd0);

      // WB forward on rs1, register file on rs2
      clr_a();
      instr(64'h108, 5'd9, 1, 5'd10, 1, 5'd11, 1, 0, 2'd0, 3'd0, 64'd0, 0, 16'h0033);
      a_if.wb_fwd_wen = 1; a_if.wb_fwd_rd = 5'd9; a_if.wb_fwd_data = 64'h99;
      a_if.rf_data1 = 64'h1111; a_if.rf_data2 = 64'hAA;
      sb.push_back('{64'h108, 64'h99, 64'hAA, 64'd0, 5'd11, 1'b1, 1'b0, 16'h0033});
      tick();

      // Load-use: LD x3 in EX, ADD x4, x3, x0 in ID
      clr_a();
      instr(64'h10C, 5'd3, 1, 5'd0, 1, 5'd4, 1, 0, 2'd0, 3'd0, 64'd0, 0, 16'h0044);
      a_if.ex_fwd_wen = 1; a_if.ex_fwd_rd = 5'd3; a_if.ex_fwd_load = 1; a_if.ex_fwd_data = 64'hBAD;
      a_if.rf_data2 = 64'h5;
      #1;
      chk("lu_id_ready", {63'd0, a_if.id_ready}, 64'd0);
      tick();
      chk("lu_bubble", {63'd0, a_if.ex_valid}, 64'd0);
      chk("lu_stall_cnt", {32'd0, a_if.stall_cnt}, 64'd1);
      a_if.ex_fwd_wen = 0; a_if.ex_fwd_load = 0;
      a_if.mem_fwd_wen = 1; a_if.mem_fwd_rd = 5'd3; a_if.mem_fwd_data = 64'hABCD;
      #1;
      chk("lu2_id_ready", {63'd0, a_if.id_ready}, 64'd1);
      sb.push_back('{64'h10C, 64'hABCD, 64'd0, 64'd0, 5'd4, 1'b1, 1'b0, 16'h0044});
      tick();
      chk("lu2_stall_cnt", {32'd0, a_if.stall_cnt}, 64'd1);

      // Conditional branches with op1 = -1, op2 = 1
      for (int i = 0; i < 7; i++) begin
         clr_a();
         instr(64'h8000_0000, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 2'd2, br_cond_tab[i], 64'h10, 0, 16'h0055);
         a_if.rf_data1 = 64'hFFFF_FFFF_FFFF_FFFF; a_if.rf_data2 = 64'd1;
         #1;
         chk($sformatf("br%0d_redirect", i), {63'd0, a_if.redirect}, {63'd0, br_take_tab[i]});
         chk($sformatf("br%0d_target", i), a_if.redirect_pc, br_take_tab[i] ? 64'h8000_0010 : 64'd0);
         sb.push_back('{64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 5'd0, 1'b0, 1'b0, 16'h0055});
         tick();
      end

      // JAL with a negative offset
      clr_a();
      instr(64'h3000, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 2'd3, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 16'h0066);
      #1;
      chk("jal_redirect", {63'd0, a_if.redirect}, 64'd1);
      chk("jal_target", a_if.redirect_pc, 64'h2FF8);
      sb.push_back('{64'h3000, 64'h3000, 64'd4, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 1'b1, 1'b0, 16'h0066});
      tick();

      // JALR x1, 2(x7) with x7 = 0x1001
      clr_a();
      instr(64'h2000, 5'd7, 1, 5'd0, 0, 5'd1, 1, 0, 2'd1, 3'd0, 64'd2, 1, 16'h0067);
      a_if.rf_data1 = 64'h1001;
      #1;
      chk("jalr_redirect", {63'd0, a_if.redirect}, 64'd1);
      chk("jalr_target", a_if.redirect_pc, 64'h1002);
      sb.push_back('{64'h2000, 64'h2000, 64'd4, 64'd2, 5'd1, 1'b1, 1'b0, 16'h0067});
      tick();
      clr_a();
      tick();
      chk("drain_ex_valid", {63'd0, a_if.ex_valid}, 64'd0);

      // Same JALR squashed by a same-cycle flush
      instr(64'h2000, 5'd7, 1, 5'd0, 0, 5'd1, 1, 0, 2'd1, 3'd0, 64'd2, 1, 16'h0067);
      a_if.rf_data1 = 64'h1001; a_if.flush = 1;
      #1;
      chk("flush_redirect", {63'd0, a_if.redirect}, 64'd0);
      chk("flush_target", a_if.redirect_pc, 64'd0);
      tick();
      chk("flush_ex_valid", {63'd0, a_if.ex_valid}, 64'd0);

      // Back-pressure: load a payload, then hold it with ex_ready low
      clr_a();
      instr(64'h4000, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 2'd0, 3'd0, 64'h20, 1, 16'h0077);
      sb.push_back('{64'h4000, 64'd0, 64'h20, 64'h20, 5'd8, 1'b1, 1'b1, 16'h0077});
      tick();
      a_if.ex_ready = 0;
      instr(64'h4004, 5'd12, 1, 5'd13, 1, 5'd14, 1, 0, 2'd0, 3'd0, 64'd0, 0, 16'h0088);
      a_if.rf_data1 = 64'h1234; a_if.rf_data2 = 64'h5678;
      #1;
      chk("bp_id_ready", {63'd0, a_if.id_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp%0d_ex_valid", i), {63'd0, a_if.ex_valid}, 64'd1);
         chk($sformatf("bp%0d_ex_pc", i), a_if.ex_pc, 64'h4000);
         chk($sformatf("bp%0d_ex_data2", i), a_if.ex_data2, 64'h20);
         chk($sformatf("bp%0d_id_ready", i), {63'd0, a_if.id_ready}, 64'd0);
      end
      chk("bp_stall_cnt", {32'd0, a_if.stall_cnt}, 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_ex_valid", {63'd0, a_if.ex_valid}, 64'd0);
      chk("mid_rst_stall_cnt", {32'd0, a_if.stall_cnt}, 64'd0);
      chk("mid_rst_ex_pc", a_if.ex_pc, 64'd0);
      if (sb.size() > 0) drop = sb.pop_front();
      clr_a();
      tick();
      reset = 1'b0;
      tick();

      // FWD_EN=0: MEM and WB both write x5 while ID reads it
      clr_b();
      b_if.id_valid = 1; b_if.pc_i = 64'h500; b_if.rs1_addr = 5'd5; b_if.rs1_used = 1;
      b_if.rd_addr = 5'd6; b_if.rd_wen = 1; b_if.rf_data1 = 64'h55;
      b_if.mem_fwd_wen = 1; b_if.mem_fwd_rd = 5'd5; b_if.mem_fwd_data = 64'hEE;
      b_if.wb_fwd_wen = 1; b_if.wb_fwd_rd = 5'd5; b_if.wb_fwd_data = 64'hDD;
      #1;
      chk("nf_id_ready0", {63'd0, b_if.id_ready}, 64'd0);
      tick();
      b_if.mem_fwd_wen = 0; b_if.wb_fwd_data = 64'hEE;
      #1;
      chk("nf_id_ready1", {63'd0, b_if.id_ready}, 64'd0);
      tick();
      b_if.wb_fwd_wen = 0;
      #1;
      chk("nf_id_ready2", {63'd0, b_if.id_ready}, 64'd1);
      tick();
      chk("nf_ex_valid", {63'd0, b_if.ex_valid}, 64'd1);
      chk("nf_ex_data1", b_if.ex_data1, 64'h55);
      chk("nf_stall_cnt", {32'd0, b_if.stall_cnt}, 64'd2);
      clr_b();

      tick();
      tick();
      chk("sb_empty", sb.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ysyx_22040931_id_pipe.md
Name: ysyx_22040931_id_pipe

Overview:
- Pipelined decode stage for the 5-stage ysyx core; replaces the single-cycle decode path.
- Sits between the IF/ID register and EX. Takes decoded fields from the existing decoder and raw register-file read data.
- Resolves operand hazards: forwarding from EX/MEM/WB, load-use interlock, or full interlock when forwarding is disabled.
- Resolves branches/jumps in ID, and drives a registered ID/EX payload over a valid/ready handshake.

Parameters:
- XLEN, 64, datapath and PC width.
- CTRLW, 16, width of the opaque control bundle passed through to EX (aluop/exop/mem ops).
- FWD_EN, 1, 1 = bypass from EX/MEM/WB; 0 = stall until the hazard clears.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  IF/ID payload valid
- id_ready  out  1  stage can accept the payload this cycle
- pc_i  in  XLEN  instruction PC
- rs1_addr, rs2_addr  in  5 each  source registers
- rs1_used, rs2_used  in  1 each  source actually read
- rd_addr  in  5  destination register
- rd_wen  in  1  instruction writes rd
- is_load  in  1  instruction is a load
- br_type  in  2  0 none, 1 JALR, 2 conditional branch, 3 JAL
- br_cond  in  3  funct3 of the conditional branch
- imm  in  XLEN  sign-extended immediate
- use_imm  in  1  operand 2 is the immediate
- ctrl_i  in  CTRLW  pass-through control
- rf_data1, rf_data2  in  XLEN  register-file read data; asynchronous, not write-through
- ex_fwd_wen, ex_fwd_rd, ex_fwd_data, ex_fwd_load  in  1/5/XLEN/1  EX-stage producer
- mem_fwd_wen, mem_fwd_rd, mem_fwd_data  in  1/5/XLEN  MEM-stage producer
- wb_fwd_wen, wb_fwd_rd, wb_fwd_data  in  1/5/XLEN  WB-stage producer
- flush  in  1  squash from a later stage
- ex_ready  in  1  EX accepts
- ex_valid  out  1  ID/EX payload valid
- ex_pc, ex_data1, ex_data2, ex_imm  out  XLEN each  registered operands
- ex_rd, ex_rd_wen, ex_is_load, ex_ctrl  out  5/1/1/CTRLW  registered control
- redirect  out  1  taken branch/jump, one-cycle pulse
- redirect_pc  out  XLEN  target PC
- stall_cnt  out  CNT_W  cycles with id_valid=1 and hazard stall

Behaviour:
- Reset (async): ex_valid=0, all ex_* payload=0, redirect=0, stall_cnt=0.
- Operand select, per source, when used and addr!=0: take the first matching producer in priority order EX > MEM > WB, else rf_data. Address 0 always yields 0.
- A producer matches when its wen=1 and its rd equals the source address.
- Hazard, FWD_EN=1: only an EX match with ex_fwd_load=1 (load-use).
- Hazard, FWD_EN=0: any match in EX, MEM or WB.
- Branch logic uses the forwarded operands:
  - JAL target = pc_i+imm.
  - JALR target = (op1+imm) with bit0 cleared.
  - Conditional branch target = pc_i+imm when taken. Conditions: BEQ/BNE/BLT/BGE/BLTU/BGEU; funct3 010/011 = never taken.
  - Overflow wraps mod 2^XLEN.
- Writeback value for JAL/JALR: ex_data1 = pc_i, ex_data2 = 4. EX performs the add.
- Non-jump operands: ex_data1 = op1; ex_data2 = use_imm ? imm : op2.
- id_ready = !hazard && (!ex_valid || ex_ready). Fire = id_valid && id_ready.
- Register update, in priority order:
  - flush: ex_valid <= 0.
  - Fire: load payload, ex_valid <= 1.
  - ex_ready && !fire: ex_valid <= 0.
  - Otherwise hold the payload unchanged (back-pressure; no bubble injected over valid data).
- redirect: combinational = fire && taken && !flush. redirect_pc is valid only while redirect=1, else 0. IF squashes its slot on redirect.
- flush has priority over a same-cycle fire: nothing is loaded and no redirect is issued.
- stall_cnt increments when id_valid && hazard && !flush, and saturates at all-ones.
- Hazard stall: payload is not accepted. When ex_ready=1 and the stage is not firing, ex_valid drops, so a bubble enters EX.
- Simultaneous wb write and read of the same register: the WB forward covers it (FWD_EN=1) or a stall covers it (FWD_EN=0).
- Reset mid-stall: all state clears and the pending instruction is dropped. IF re-presents it.

Test Plan:
- ALU chain: ADDI x1=5, then ADD x2,x1,x1 on consecutive cycles, FWD_EN=1 -> no stall; EX-forward gives ex_data1=ex_data2=5; stall_cnt stays 0.
- Load-use: LD x3 in EX (ex_fwd_load=1, rd=3), then ADD x4,x3,x0 -> id_ready=0 for 1 cycle, bubble ex_valid=0, stall_cnt=1; next cycle MEM-forward with mem_fwd_data=0xABCD gives ex_data1=0xABCD.
- FWD_EN=0, MEM and WB both writing x5 while ID reads x5 -> stalls until no match (2 cycles), then ex_data1=rf_data1.
- BLT with op1=-1, op2=1, pc=0x8000_0000, imm=0x10 -> redirect=1, redirect_pc=0x8000_0010; BLTU with the same operands -> redirect=0.
- JALR with op1=0x1001, imm=2 -> redirect_pc=0x1002, ex_data1=pc, ex_data2=4; with flush=1 in the same cycle -> redirect=0, ex_valid=0.
- Back-pressure: ex_ready=0 for 3 cycles with valid payload -> ex_* held, id_ready=0; reset asserted mid-hold -> ex_valid=0, stall_cnt=0 immediately.
